// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: FSM encoding, pipe slot layout and PC helpers.
package branch_resolver_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] target;
    } slot_t;

    // Fetch address for a branch that turned out not taken.
    function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Decode/MEM side of the branch-prediction link plus the flush/training outputs.
interface branch_resolver_if;

    logic        stall;
    logic        decode_branch;
    logic        decode_prediction;
    logic [31:0] decode_pc;
    logic [31:0] decode_target;
    logic        mem_taken;

    logic        flush;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic        update_taken;

    modport master (
        output stall, decode_branch, decode_prediction, decode_pc, decode_target, mem_taken,
        input  flush, redirect_pc, update_valid, update_taken
    );

    modport slave (
        input  stall, decode_branch, decode_prediction, decode_pc, decode_target, mem_taken,
        output flush, redirect_pc, update_valid, update_taken
    );

endinterface

// File: rtl/branch_tag_pipe.sv
// Shift register carrying captured branch predictions from decode to the MEM compare slot.
module branch_tag_pipe
    import branch_resolver_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  advance,
    input  logic  kill,
    input  slot_t slot_in,
    output slot_t slot_out
);

    slot_t slots [PIPE_DEPTH];

    // Kill only drops valid bits; stale payload is harmless once invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (kill) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slots[k].valid <= 1'b0;
            end
        end else if (advance) begin
            slots[0] <= slot_in;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    assign slot_out = slots[PIPE_DEPTH-1];

endmodule

// File: rtl/branch_resolver.sv
// Resolves carried predictions against the MEM-stage decision, drives flush/redirect,
// predictor training and performance counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int FLUSH_LEN  = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    state_t      state_q, state_d;
    logic [FCW-1:0] cnt_q, cnt_d;

    slot_t       cap_slot;
    slot_t       res_slot;
    logic        advance;
    logic        resolve;
    logic        mispredict;

    logic        update_valid_q;
    logic        update_taken_q;
    logic [31:0] redirect_pc_q;

    always_comb begin
        cap_slot.valid  = bus.decode_branch & (state_q == S_RUN);
        cap_slot.pred   = bus.decode_prediction;
        cap_slot.pc     = bus.decode_pc;
        cap_slot.target = bus.decode_target;
    end

    assign advance    = ~bus.stall;
    assign resolve    = res_slot.valid & advance;
    assign mispredict = resolve & (res_slot.pred != bus.mem_taken);

    // A mispredict kills everything younger, including a branch entering decode on that edge.
    branch_tag_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .kill     (mispredict),
        .slot_in  (cap_slot),
        .slot_out (res_slot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The squash window counts down regardless of stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (mispredict) begin
                    state_d = S_FLUSH;
                    cnt_d   = FCW'(FLUSH_LEN - 1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - FCW'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_valid_q   <= 1'b0;
            update_taken_q   <= 1'b0;
            redirect_pc_q    <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            update_valid_q <= resolve;
            if (resolve) begin
                update_taken_q <= bus.mem_taken;
                branch_count   <= branch_count + CNT_W'(1);
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
                redirect_pc_q    <= bus.mem_taken ? res_slot.target : fallthrough_pc(res_slot.pc);
            end
        end
    end

    assign bus.flush        = (state_q == S_FLUSH);
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.update_valid = update_valid_q;
    assign bus.update_taken = update_taken_q;

endmodule
